// File: rtl/imem_responder_if.sv
// Fetch-side bus of the instruction-memory responder: request/response
// handshakes, program-load write port and busy status.
interface imem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_data_o;
  logic [ADDR_W-1:0] rsp_addr_o;
  logic              rsp_err_o;
  logic              wr_en_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              busy_o;

  modport slave (
    input  req_valid_i, req_addr_i, rsp_ready_i, wr_en_i, wr_addr_i, wr_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_addr_o, rsp_err_o, busy_o
  );

  modport master (
    output req_valid_i, req_addr_i, rsp_ready_i, wr_en_i, wr_addr_i, wr_data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_addr_o, rsp_err_o, busy_o
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: one request at a time, fixed-latency response
// held under backpressure. Define IMEM_BOUNDS_EN to flag out-of-range reads.
module imem_responder #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 128,
  parameter int LATENCY   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_responder_if.slave  bus
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [3:0]      CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            nextState_s;
  logic [3:0]        cnt_r;
  logic [3:0]        cntNext_s;
  logic              accept_s;
  logic              rspValid_r;
  logic [DATA_W-1:0] rspData_r;
  logic [ADDR_W-1:0] rspAddr_r;
  logic              rspErr_r;

  logic [DATA_W-1:0] mem_r [2**IDX_W];
  logic              rdInRange_s;
  logic              wrInRange_s;
  logic [DATA_W-1:0] rdWord_s;
  logic              rdErr_s;

  // Address decode and read-word selection for the request being offered
  always_comb begin
    rdInRange_s = ({1'b0, bus.req_addr_i} < DEPTH_L);
    wrInRange_s = ({1'b0, bus.wr_addr_i} < DEPTH_L);
    if (rdInRange_s) begin
      rdWord_s = mem_r[bus.req_addr_i[IDX_W-1:0]];
    end else begin
      rdWord_s = {DATA_W{1'b0}};
    end
`ifdef IMEM_BOUNDS_EN
    rdErr_s = ~rdInRange_s;
`else
    rdErr_s = 1'b0;
`endif
  end

  // Program-load write port; out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (bus.wr_en_i && wrInRange_s) begin
      mem_r[bus.wr_addr_i[IDX_W-1:0]] <= bus.wr_data_i;
    end
  end

  // Next-state and latency-counter logic
  always_comb begin
    nextState_s = state_r;
    cntNext_s   = cnt_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req_valid_i) begin
          accept_s = 1'b1;
          if (LATENCY == 1) begin
            nextState_s = RESP;
          end else begin
            nextState_s = WAIT;
            cntNext_s   = CNT_LOAD;
          end
        end else begin
          nextState_s = IDLE;
        end
      end
      WAIT: begin
        cntNext_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          nextState_s = RESP;
        end else begin
          nextState_s = WAIT;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          nextState_s = IDLE;
        end else begin
          nextState_s = RESP;
        end
      end
      default: begin
        nextState_s = IDLE;
        cntNext_s   = 4'd0;
      end
    endcase
  end

  // State, counter and response registers; the word is captured at accept so
  // later writes cannot disturb an in-flight response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      rspValid_r <= 1'b0;
      rspData_r  <= {DATA_W{1'b0}};
      rspAddr_r  <= {ADDR_W{1'b0}};
      rspErr_r   <= 1'b0;
    end else begin
      state_r    <= nextState_s;
      cnt_r      <= cntNext_s;
      rspValid_r <= (nextState_s == RESP);
      if (accept_s) begin
        rspData_r <= rdWord_s;
        rspAddr_r <= bus.req_addr_i;
        rspErr_r  <= rdErr_s;
      end
    end
  end

  assign bus.req_ready_o = (state_r == IDLE);
  assign bus.busy_o      = (state_r != IDLE);
  assign bus.rsp_valid_o = rspValid_r;
  assign bus.rsp_data_o  = rspData_r;
  assign bus.rsp_addr_o  = rspAddr_r;
  assign bus.rsp_err_o   = rspErr_r;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a LATENCY=2 instance driven from a vector
// table plus hand sequences, and a LATENCY=1 instance for back-to-back fetches.
module tb_imem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;

`ifdef IMEM_BOUNDS_EN
  localparam logic ERR_OOR = 1'b1;
`else
  localparam logic ERR_OOR = 1'b0;
`endif

  imem_responder_if #(.ADDR_W(8), .DATA_W(16)) aIf ();
  imem_responder_if #(.ADDR_W(8), .DATA_W(16)) bIf ();

  imem_responder #(.ADDR_W(8), .DATA_W(16), .MEM_DEPTH(128), .LATENCY(2))
    dutA (.clk(clk), .rst_n(rst_n), .bus(aIf.slave));
  imem_responder #(.ADDR_W(8), .DATA_W(16), .MEM_DEPTH(128), .LATENCY(1))
    dutB (.clk(clk), .rst_n(rst_n), .bus(bIf.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        wrEn;
    logic [7:0]  wrAddr;
    logic [15:0] wrData;
    logic [7:0]  reqAddr;
    int          stall;
    logic [15:0] expData;
    logic        expErr;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic writeMem(input logic [7:0] a, input logic [15:0] d);
    aIf.wr_en_i = 1'b1; aIf.wr_addr_i = a; aIf.wr_data_i = d;
    bIf.wr_en_i = 1'b1; bIf.wr_addr_i = a; bIf.wr_data_i = d;
    @(negedge clk);
    aIf.wr_en_i = 1'b0;
    bIf.wr_en_i = 1'b0;
  endtask

  // Called one negedge after the accept edge; returns edges since accept.
  task automatic waitRspA(output int edges);
    edges = 1;
    while (!aIf.rsp_valid_o && edges < 20) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic doReq(input logic [7:0] a, input int stall, input logic [15:0] ed,
                       input logic ee, input string nm);
    int   edges;
    logic ok;
    chk({nm, "_ready"}, 32'(aIf.req_ready_o), 32'd1);
    aIf.req_valid_i = 1'b1;
    aIf.req_addr_i  = a;
    @(negedge clk);
    aIf.req_valid_i = 1'b0;
    aIf.req_addr_i  = ~a;
    waitRspA(edges);
    chk({nm, "_lat"}, 32'(edges), 32'd2);
    chk({nm, "_data"}, 32'(aIf.rsp_data_o), 32'(ed));
    chk({nm, "_addr"}, 32'(aIf.rsp_addr_o), 32'(a));
    chk({nm, "_err"}, 32'(aIf.rsp_err_o), 32'(ee));
    chk({nm, "_busy"}, 32'({aIf.busy_o, aIf.req_ready_o}), 32'b10);
    ok = 1'b1;
    for (int s = 0; s < stall; s++) begin
      aIf.req_valid_i = 1'b1;
      aIf.req_addr_i  = a ^ 8'h55;
      @(negedge clk);
      if (!aIf.rsp_valid_o || aIf.rsp_data_o !== ed || aIf.rsp_addr_o !== a ||
          aIf.rsp_err_o !== ee || aIf.req_ready_o !== 1'b0) ok = 1'b0;
    end
    if (stall > 0) chk({nm, "_hold"}, 32'(ok), 32'd1);
    aIf.req_valid_i = 1'b0;
    aIf.rsp_ready_i = 1'b1;
    @(negedge clk);
    aIf.rsp_ready_i = 1'b0;
    chk({nm, "_done"}, 32'({aIf.rsp_valid_o, aIf.busy_o, aIf.req_ready_o}), 32'b001);
  endtask

  initial begin
    int          edges;
    logic        saw;
    int          waited;
    int          acc[4];

    vecs[0] = '{1'b1, 8'd5,   16'hA5C3, 8'd5,   0, 16'hA5C3, 1'b0};
    vecs[1] = '{1'b1, 8'd7,   16'h1234, 8'd7,   4, 16'h1234, 1'b0};
    vecs[2] = '{1'b1, 8'd127, 16'hBEEF, 8'd127, 1, 16'hBEEF, 1'b0};
    vecs[3] = '{1'b1, 8'd0,   16'h0F0F, 8'd0,   0, 16'h0F0F, 1'b0};
    vecs[4] = '{1'b0, 8'd0,   16'h0000, 8'd200, 0, 16'h0000, ERR_OOR};
    vecs[5] = '{1'b1, 8'd72,  16'h7272, 8'd72,  0, 16'h7272, 1'b0};
    vecs[6] = '{1'b1, 8'd200, 16'hDEAD, 8'd72,  0, 16'h7272, 1'b0};
    vecs[7] = '{1'b0, 8'd0,   16'h0000, 8'd200, 2, 16'h0000, ERR_OOR};
    vecs[8] = '{1'b1, 8'd128, 16'hCAFE, 8'd128, 0, 16'h0000, ERR_OOR};
    vecs[9] = '{1'b0, 8'd0,   16'h0000, 8'd5,   0, 16'hA5C3, 1'b0};

    aIf.req_valid_i = 1'b0; aIf.req_addr_i = 8'd0; aIf.rsp_ready_i = 1'b0;
    aIf.wr_en_i = 1'b0; aIf.wr_addr_i = 8'd0; aIf.wr_data_i = 16'd0;
    bIf.req_valid_i = 1'b0; bIf.req_addr_i = 8'd0; bIf.rsp_ready_i = 1'b0;
    bIf.wr_en_i = 1'b0; bIf.wr_addr_i = 8'd0; bIf.wr_data_i = 16'd0;

    repeat (2) @(negedge clk);
    chk("rst_ready_busy", 32'({aIf.req_ready_o, aIf.busy_o}), 32'b10);
    chk("rst_valid_err", 32'({aIf.rsp_valid_o, aIf.rsp_err_o}), 32'b00);
    chk("rst_data_addr", 32'({aIf.rsp_data_o, aIf.rsp_addr_o}), 32'd0);
    chk("rst_b_ready_busy", 32'({bIf.req_ready_o, bIf.busy_o, bIf.rsp_valid_o}), 32'b100);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wrEn) writeMem(vecs[i].wrAddr, vecs[i].wrData);
      doReq(vecs[i].reqAddr, vecs[i].stall, vecs[i].expData, vecs[i].expErr,
            $sformatf("vec%0d", i));
    end

    // Same-edge write and accept of addr 10 must return the old word.
    writeMem(8'd10, 16'h1111);
    aIf.wr_en_i = 1'b1; aIf.wr_addr_i = 8'd10; aIf.wr_data_i = 16'h2222;
    aIf.req_valid_i = 1'b1; aIf.req_addr_i = 8'd10;
    @(negedge clk);
    aIf.wr_en_i = 1'b0; aIf.req_valid_i = 1'b0;
    waitRspA(edges);
    chk("coll_lat", 32'(edges), 32'd2);
    chk("coll_data", 32'(aIf.rsp_data_o), 32'h1111);
    aIf.rsp_ready_i = 1'b1;
    @(negedge clk);
    aIf.rsp_ready_i = 1'b0;
    doReq(8'd10, 0, 16'h2222, 1'b0, "coll_reread");

    // Reset while in WAIT abandons the transaction.
    aIf.req_valid_i = 1'b1; aIf.req_addr_i = 8'd5;
    @(negedge clk);
    aIf.req_valid_i = 1'b0;
    chk("mid_busy_before", 32'(aIf.busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_in_reset", 32'({aIf.rsp_valid_o, aIf.busy_o, aIf.req_ready_o}), 32'b001);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (aIf.rsp_valid_o || aIf.busy_o) saw = 1'b1;
    end
    chk("mid_no_rsp", 32'(saw), 32'd0);
    doReq(8'd5, 0, 16'hA5C3, 1'b0, "mid_mem_kept");

    // LATENCY=1: back-to-back fetches of addrs 0..3.
    for (int i = 0; i < 4; i++) writeMem(8'(i), 16'hC0A0 + 16'(i));
    bIf.rsp_ready_i = 1'b1;
    bIf.req_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waited = 0;
      while (!bIf.req_ready_o && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      chk($sformatf("l1_wait%0d", i), 32'(waited < 10), 32'd1);
      bIf.req_addr_i = 8'(i);
      acc[i] = cyc;
      @(negedge clk);
      chk($sformatf("l1_valid%0d", i), 32'(bIf.rsp_valid_o), 32'd1);
      chk($sformatf("l1_data%0d", i), 32'(bIf.rsp_data_o), 32'hC0A0 + 32'(i));
      chk($sformatf("l1_addr%0d", i), 32'(bIf.rsp_addr_o), 32'(i));
      if (i > 0) chk($sformatf("l1_spacing%0d", i), 32'(acc[i] - acc[i-1]), 32'd2);
    end
    bIf.req_valid_i = 1'b0;
    @(negedge clk);
    bIf.rsp_ready_i = 1'b0;
    chk("l1_idle", 32'({bIf.rsp_valid_o, bIf.busy_o, bIf.req_ready_o}), 32'b001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
